// File: rtl/reg_scoreboard_pkg.sv
// Shared encodings for the register-hazard scoreboard: producer classes,
// pipeline ages and forward-source selects.
package reg_scoreboard_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MD   = 2'd2,
    CLS_RSV  = 2'd3
  } cls_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam logic [1:0] AGE_EX  = 2'd0;
  localparam logic [1:0] AGE_MEM = 2'd1;
  localparam logic [1:0] AGE_WB  = 2'd2;

  // The reserved class code behaves exactly like an ALU producer.
  function automatic cls_t norm_class(input logic [1:0] c);
    case (c)
      2'd1:    return CLS_LOAD;
      2'd2:    return CLS_MD;
      default: return CLS_ALU;
    endcase
  endfunction

  function automatic logic [1:0] age_to_fwd(input logic [1:0] age);
    case (age)
      AGE_EX:  return FWD_EX;
      AGE_MEM: return FWD_MEM;
      default: return FWD_WB;
    endcase
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// One architectural register's in-flight writer: pending flag, pipeline age
// and producer class, plus whether its value can be forwarded right now.
module sb_entry
  import reg_scoreboard_pkg::*;
#(
  parameter int LOAD_READY_AGE = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       write,
  input  cls_t       write_class,
  input  logic       md_idle,
  output logic       pending,
  output logic [1:0] age,
  output logic       ready
);

  localparam logic [1:0] LOAD_AGE = 2'(LOAD_READY_AGE);

  cls_t cls;
  logic md_hold;

  // A mul/div result stays parked in EX until the unit finishes.
  assign md_hold = (cls == CLS_MD) && (age == AGE_EX) && !md_idle;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending <= 1'b0;
      age     <= AGE_EX;
      cls     <= CLS_ALU;
    end else if (write) begin
      pending <= 1'b1;
      age     <= AGE_EX;
      cls     <= write_class;
    end else if (pending && !md_hold) begin
      if (age == AGE_WB) begin
        pending <= 1'b0;
      end else begin
        age <= age + 2'd1;
      end
    end
  end

  always_comb begin
    ready = 1'b1;
    case (cls)
      CLS_LOAD: ready = (age >= LOAD_AGE);
      CLS_MD:   ready = md_idle;
      default:  ready = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_scoreboard.sv
// ID-stage register-hazard scheduler: tracks writers to $1..$31, picks the
// bypass source per operand, and stalls on unready producers or busy mul/div.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int LAT_MD         = 8,
  parameter int LOAD_READY_AGE = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       id_valid,
  input  logic       id_rs_ren,
  input  logic [4:0] id_rs,
  input  logic       id_rt_ren,
  input  logic [4:0] id_rt,
  input  logic       id_we,
  input  logic [4:0] id_waddr,
  input  logic [1:0] id_class,
  input  logic       flush,
  output logic       stallreq,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic       md_busy
);

  localparam int              CNT_W   = (LAT_MD > 1) ? $clog2(LAT_MD) : 1;
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(LAT_MD - 1);

  logic [CNT_W-1:0] md_cnt;
  logic             accept;
  logic             md_idle;
  cls_t             id_cls;
  logic [31:0]      pend;
  logic [31:0]      rdy;
  logic [1:0]       age [32];
  logic             rs_hit, rt_hit, rs_hazard, rt_hazard;

  assign id_cls  = norm_class(id_class);
  assign md_idle = (md_cnt == '0);
  assign md_busy = !md_idle;
  assign accept  = id_valid && !stallreq && !flush;

  // $0 is hardwired: never pending, so lookups on it always pick the RF.
  assign pend[0] = 1'b0;
  assign rdy[0]  = 1'b1;
  assign age[0]  = AGE_EX;

  for (genvar r = 1; r < 32; r++) begin : g_entry
    sb_entry #(
      .LOAD_READY_AGE(LOAD_READY_AGE)
    ) u_entry (
      .clk        (clk),
      .resetn     (resetn),
      .write      (accept && id_we && (id_waddr == 5'(r))),
      .write_class(id_cls),
      .md_idle    (md_idle),
      .pending    (pend[r]),
      .age        (age[r]),
      .ready      (rdy[r])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      md_cnt <= '0;
    end else if (accept && (id_cls == CLS_MD)) begin
      md_cnt <= MD_LOAD;
    end else if (!md_idle) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  // Selects are computed even when stalling; upstream only uses them on issue.
  always_comb begin
    rs_hit     = id_rs_ren && (id_rs != 5'd0) && pend[id_rs];
    rt_hit     = id_rt_ren && (id_rt != 5'd0) && pend[id_rt];
    rs_hazard  = rs_hit && !rdy[id_rs];
    rt_hazard  = rt_hit && !rdy[id_rt];
    fwd_rs_sel = rs_hit ? age_to_fwd(age[id_rs]) : FWD_RF;
    fwd_rt_sel = rt_hit ? age_to_fwd(age[id_rt]) : FWD_RF;
    stallreq   = id_valid && (md_busy || rs_hazard || rt_hazard);
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench for reg_scoreboard: each step pushes the expected
// {stallreq, fwd_rs_sel, fwd_rt_sel, md_busy} and pops it once outputs settle.
module tb_reg_scoreboard;

  logic       clk;
  logic       resetn;
  logic       id_valid;
  logic       id_rs_ren;
  logic [4:0] id_rs;
  logic       id_rt_ren;
  logic [4:0] id_rt;
  logic       id_we;
  logic [4:0] id_waddr;
  logic [1:0] id_class;
  logic       flush;
  logic       stallreq;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic       md_busy;

  typedef struct {
    string      tag;
    logic [5:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  reg_scoreboard #(
    .LAT_MD(8),
    .LOAD_READY_AGE(1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .id_valid  (id_valid),
    .id_rs_ren (id_rs_ren),
    .id_rs     (id_rs),
    .id_rt_ren (id_rt_ren),
    .id_rt     (id_rt),
    .id_we     (id_we),
    .id_waddr  (id_waddr),
    .id_class  (id_class),
    .flush     (flush),
    .stallreq  (stallreq),
    .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel),
    .md_busy   (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output();
    exp_t       e;
    logic [5:0] obs;
    e   = sb_q.pop_front();
    obs = {stallreq, fwd_rs_sel, fwd_rt_sel, md_busy};
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("[TB] FAIL %s observed={stall,rs,rt,busy}=%b expected=%b", e.tag, obs, e.val);
    end
  endtask

  // Drive one ID cycle after the falling edge, check before the rising edge.
  task automatic apply_stimulus(
    input string      tag,
    input logic       rstn, input logic v, input logic fl,
    input logic       rsr, input logic [4:0] rs,
    input logic       rtr, input logic [4:0] rt,
    input logic       we, input logic [4:0] wa, input logic [1:0] cls,
    input logic       e_stall, input logic [1:0] e_rs, input logic [1:0] e_rt,
    input logic       e_busy);
    exp_t e;
    @(negedge clk);
    resetn    = rstn;
    id_valid  = v;
    flush     = fl;
    id_rs_ren = rsr;
    id_rs     = rs;
    id_rt_ren = rtr;
    id_rt     = rt;
    id_we     = we;
    id_waddr  = wa;
    id_class  = cls;
    e.tag = tag;
    e.val = {e_stall, e_rs, e_rt, e_busy};
    sb_q.push_back(e);
    #2;
    check_output();
  endtask

  initial begin
    resetn = 1'b0; id_valid = 1'b1; flush = 1'b0;
    id_rs_ren = 1'b1; id_rs = 5'd3; id_rt_ren = 1'b1; id_rt = 5'd5;
    id_we = 1'b1; id_waddr = 5'd3; id_class = 2'd1;
    repeat (2) @(posedge clk);

    // reset held with a valid, writing instruction in ID
    apply_stimulus("reset0", 0,1,0, 1,5'd3, 1,5'd5, 1,5'd3,2'd1, 0,2'd0,2'd0,0);
    apply_stimulus("reset1", 0,1,0, 1,5'd3, 1,5'd5, 1,5'd3,2'd1, 0,2'd0,2'd0,0);

    // ALU chain on $3, then a load reissued to $3 as the old entry retires
    apply_stimulus("alu_issue", 1,1,0, 0,5'd0, 0,5'd0, 1,5'd3,2'd0, 0,2'd0,2'd0,0);
    apply_stimulus("alu_ex",    1,1,0, 1,5'd3, 0,5'd0, 0,5'd0,2'd0, 0,2'd1,2'd0,0);
    apply_stimulus("alu_mem",   1,1,0, 1,5'd3, 0,5'd0, 0,5'd0,2'd0, 0,2'd2,2'd0,0);
    apply_stimulus("alu_wb_reissue", 1,1,0, 1,5'd3, 0,5'd0, 1,5'd3,2'd1, 0,2'd3,2'd0,0);
    apply_stimulus("reissue_wins_stall", 1,1,0, 1,5'd3, 0,5'd0, 0,5'd0,2'd0, 1,2'd1,2'd0,0);
    apply_stimulus("reissue_mem",  1,1,0, 1,5'd3, 0,5'd0, 0,5'd0,2'd0, 0,2'd2,2'd0,0);
    apply_stimulus("reissue_wb",   1,0,0, 1,5'd3, 0,5'd0, 0,5'd0,2'd0, 0,2'd3,2'd0,0);
    apply_stimulus("alu_retired",  1,1,0, 1,5'd3, 0,5'd0, 0,5'd0,2'd0, 0,2'd0,2'd0,0);

    // load-use on $5 through both operands
    apply_stimulus("lw_issue",  1,1,0, 0,5'd0, 0,5'd0, 1,5'd5,2'd1, 0,2'd0,2'd0,0);
    apply_stimulus("lu_stall",  1,1,0, 1,5'd5, 1,5'd5, 0,5'd0,2'd0, 1,2'd1,2'd1,0);
    apply_stimulus("lu_issue",  1,1,0, 1,5'd5, 1,5'd5, 0,5'd0,2'd0, 0,2'd2,2'd2,0);
    apply_stimulus("lu_idle",   1,0,0, 0,5'd0, 0,5'd0, 0,5'd0,2'd0, 0,2'd0,2'd0,0);

    // div writing $7: seven busy cycles stall dependent and unrelated work
    apply_stimulus("div_issue", 1,1,0, 0,5'd0, 0,5'd0, 1,5'd7,2'd2, 0,2'd0,2'd0,0);
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0)
        apply_stimulus($sformatf("md_dep_%0d", i), 1,1,0, 1,5'd7, 0,5'd0, 0,5'd0,2'd0,
                       1,2'd1,2'd0,1);
      else
        apply_stimulus($sformatf("md_other_%0d", i), 1,1,0, 1,5'd10, 0,5'd0, 1,5'd11,2'd0,
                       1,2'd0,2'd0,1);
    end
    apply_stimulus("md_consumer", 1,1,0, 1,5'd7, 0,5'd0, 0,5'd0,2'd0, 0,2'd1,2'd0,0);
    apply_stimulus("md_mem",      1,0,0, 1,5'd7, 0,5'd0, 0,5'd0,2'd0, 0,2'd2,2'd0,0);
    apply_stimulus("md_wb",       1,0,0, 1,5'd7, 0,5'd0, 0,5'd0,2'd0, 0,2'd3,2'd0,0);
    apply_stimulus("md_retired",  1,1,0, 1,5'd7, 0,5'd0, 0,5'd0,2'd0, 0,2'd0,2'd0,0);

    // lw $4 overwritten by addu $4: no load stall afterwards
    apply_stimulus("re_lw",     1,1,0, 0,5'd0, 0,5'd0, 1,5'd4,2'd1, 0,2'd0,2'd0,0);
    apply_stimulus("re_addu",   1,1,0, 0,5'd0, 0,5'd0, 1,5'd4,2'd0, 0,2'd0,2'd0,0);
    apply_stimulus("re_use_ex", 1,1,0, 1,5'd4, 0,5'd0, 0,5'd0,2'd0, 0,2'd1,2'd0,0);
    apply_stimulus("re_use_mem",1,1,0, 0,5'd0, 1,5'd4, 0,5'd0,2'd0, 0,2'd0,2'd2,0);

    // $0 writes and reads
    apply_stimulus("zero_write", 1,1,0, 1,5'd0, 1,5'd0, 1,5'd0,2'd1, 0,2'd0,2'd0,0);
    apply_stimulus("zero_read",  1,1,0, 1,5'd0, 1,5'd0, 0,5'd0,2'd0, 0,2'd0,2'd0,0);

    // flushed load leaves $6 untracked
    apply_stimulus("flush_lw",   1,1,1, 0,5'd0, 0,5'd0, 1,5'd6,2'd1, 0,2'd0,2'd0,0);
    apply_stimulus("flush_use",  1,1,0, 1,5'd6, 1,5'd6, 0,5'd0,2'd0, 0,2'd0,2'd0,0);

    // reset while mul/div busy, and reset beating an accepted write
    apply_stimulus("rst_div",    1,1,0, 0,5'd0, 0,5'd0, 1,5'd8,2'd2, 0,2'd0,2'd0,0);
    apply_stimulus("rst_busy",   1,0,0, 1,5'd8, 0,5'd0, 0,5'd0,2'd0, 0,2'd1,2'd0,1);
    apply_stimulus("rst_assert", 0,0,0, 1,5'd8, 0,5'd0, 0,5'd0,2'd0, 0,2'd1,2'd0,1);
    apply_stimulus("rst_cleared",1,1,0, 1,5'd8, 0,5'd0, 0,5'd0,2'd0, 0,2'd0,2'd0,0);
    apply_stimulus("rst_vs_lw",  0,1,0, 0,5'd0, 0,5'd0, 1,5'd9,2'd1, 0,2'd0,2'd0,0);
    apply_stimulus("rst_lw_gone",1,1,0, 1,5'd9, 1,5'd9, 0,5'd0,2'd0, 0,2'd0,2'd0,0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
